// File: rtl/multicycle_controller.sv
// Multi-cycle FSM controller for the RV32I-subset core: sequences fetch, decode, execute,
// memory and writeback over one shared ALU and a unified memory with a bounded ready wait.
module multicycle_controller #(
    parameter int ALUOP_W     = 3,
    parameter bit UNSIGNED_BR = 1'b1,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               zero,
    input  logic               negetive,
    input  logic               ltu,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcsrc,
    output logic               adrsrc,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUOP_W-1:0] aluop,
    output logic [2:0]         immsrc,
    output logic [1:0]         fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB,
        MEM_WRITE, BRANCH, JAL, JALR1, JALR2, LUI, TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_ILL  = 2'b01;
    localparam logic [1:0] FLT_TMO  = 2'b10;

    state_t          state, state_next;
    logic [CW-1:0]   wait_cnt, wait_cnt_next;
    logic [1:0]      fault_next;
    logic [2:0]      alu3;
    logic            illegal;
    logic            take;
    logic            waiting;
    logic            timed_out;

    // Only the memory-facing states count stalled cycles; a ready in the limit cycle wins.
    assign waiting   = (state inside {FETCH, MEM_READ, MEM_WRITE}) && !mem_ready;
    assign timed_out = waiting && (wait_cnt == CW'(TIMEOUT));
    assign aluop     = ALUOP_W'(alu3);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            fault    <= FLT_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            fault    <= fault_next;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (state_next != state) wait_cnt_next = '0;
        else if (waiting)        wait_cnt_next = wait_cnt + CW'(1);
    end

    // NOTE: every output and next-state term gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        fault_next = fault;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        adrsrc     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        alu3       = ALU_ADD;
        immsrc     = IMM_I;
        illegal    = 1'b0;
        take       = 1'b0;

        unique case (state)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b10;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_R:     state_next = EXEC_R;
                    OP_I:     state_next = EXEC_I;
                    OP_LOAD:  begin
                        if (func3 == 3'b010) state_next = MEM_ADDR;
                        else                 illegal = 1'b1;
                    end
                    OP_STORE: begin
                        immsrc = IMM_S;
                        if (func3 == 3'b010) state_next = MEM_ADDR;
                        else                 illegal = 1'b1;
                    end
                    OP_BR:    begin immsrc = IMM_B; state_next = BRANCH; end
                    OP_JAL:   begin immsrc = IMM_J; state_next = JAL;    end
                    OP_JALR:  begin
                        if (func3 == 3'b000) state_next = JALR1;
                        else                 illegal = 1'b1;
                    end
                    OP_LUI:   begin immsrc = IMM_U; state_next = LUI;    end
                    default:  illegal = 1'b1;
                endcase
            end
            EXEC_R: begin
                alusrca    = 2'b10;
                state_next = ALU_WB;
                case ({func7, func3})
                    {7'b0000000, 3'b000}: alu3 = ALU_ADD;
                    {7'b0100000, 3'b000}: alu3 = ALU_SUB;
                    {7'b0000000, 3'b010}: alu3 = ALU_SLT;
                    {7'b0000000, 3'b011}: alu3 = ALU_SLTU;
                    {7'b0000000, 3'b100}: alu3 = ALU_XOR;
                    {7'b0000000, 3'b110}: alu3 = ALU_OR;
                    {7'b0000000, 3'b111}: alu3 = ALU_AND;
                    default:              illegal = 1'b1;
                endcase
            end
            EXEC_I: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                state_next = ALU_WB;
                case (func3)
                    3'b000:  alu3 = ALU_ADD;
                    3'b010:  alu3 = ALU_SLT;
                    3'b011:  alu3 = ALU_SLTU;
                    3'b100:  alu3 = ALU_XOR;
                    3'b110:  alu3 = ALU_OR;
                    3'b111:  alu3 = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
            ALU_WB: begin
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                immsrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                state_next = (op == OP_STORE) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                adrsrc  = 1'b1;
                memread = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                regwrite   = 1'b1;
                resultsrc  = 2'b01;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            BRANCH: begin
                alusrca    = 2'b10;
                alu3       = ALU_SUB;
                pcsrc      = 1'b1;
                immsrc     = IMM_B;
                state_next = FETCH;
                case (func3)
                    3'b000:  take = zero;
                    3'b001:  take = !zero;
                    3'b100:  take = negetive;
                    3'b101:  take = !negetive;
                    3'b110:  if (UNSIGNED_BR) take = ltu;  else illegal = 1'b1;
                    3'b111:  if (UNSIGNED_BR) take = !ltu; else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
                pcwrite = take;
            end
            JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                pcsrc      = 1'b1;
                pcwrite    = 1'b1;
                regwrite   = 1'b1;
                resultsrc  = 2'b10;
                immsrc     = IMM_J;
                state_next = FETCH;
            end
            JALR1: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                state_next = JALR2;
            end
            JALR2: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                pcwrite    = 1'b1;
                regwrite   = 1'b1;
                state_next = FETCH;
            end
            LUI: begin
                regwrite   = 1'b1;
                resultsrc  = 2'b11;
                immsrc     = IMM_U;
                state_next = FETCH;
            end
            TRAP:    state_next = TRAP;
            default: state_next = FETCH;
        endcase

        if (illegal) begin
            state_next = TRAP;
            fault_next = FLT_ILL;
        end else if (timed_out) begin
            state_next = TRAP;
            fault_next = FLT_TMO;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states
// and compares the full control word against hand-derived values.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcwrite, pcsrc, adrsrc, memread, memwrite, irwrite, regwrite;
        logic [1:0] resultsrc, alusrca, alusrcb;
        logic [2:0] aluop, immsrc;
        logic [1:0] fault;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, negetive, ltu, mem_ready;

    logic       pcwrite, pcsrc, adrsrc, memread, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, fault;
    logic [2:0] aluop, immsrc;
    logic       pcwrite0, pcsrc0, adrsrc0, memread0, memwrite0, irwrite0, regwrite0;
    logic [1:0] resultsrc0, alusrca0, alusrcb0, fault0;
    logic [2:0] aluop0, immsrc0;

    ctrl_t obs, obs0, e;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUOP_W(3), .UNSIGNED_BR(1'b1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .negetive(negetive), .ltu(ltu), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .adrsrc(adrsrc), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .immsrc(immsrc), .fault(fault)
    );

    multicycle_controller #(.ALUOP_W(3), .UNSIGNED_BR(1'b0), .TIMEOUT(4)) dut0 (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero),
        .negetive(negetive), .ltu(ltu), .mem_ready(mem_ready),
        .pcwrite(pcwrite0), .pcsrc(pcsrc0), .adrsrc(adrsrc0), .memread(memread0),
        .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0), .resultsrc(resultsrc0),
        .alusrca(alusrca0), .alusrcb(alusrcb0), .aluop(aluop0), .immsrc(immsrc0), .fault(fault0)
    );

    assign obs  = {pcwrite, pcsrc, adrsrc, memread, memwrite, irwrite, regwrite,
                   resultsrc, alusrca, alusrcb, aluop, immsrc, fault};
    assign obs0 = {pcwrite0, pcsrc0, adrsrc0, memread0, memwrite0, irwrite0, regwrite0,
                   resultsrc0, alusrca0, alusrcb0, aluop0, immsrc0, fault0};

    task automatic check(input string tag, input ctrl_t observed, input ctrl_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t fetch_e(input logic rdy);
        ctrl_t c = '0;
        c.memread = 1'b1;
        c.alusrcb = 2'b10;
        c.irwrite = rdy;
        c.pcwrite = rdy;
        return c;
    endfunction

    function automatic ctrl_t decode_e(input logic [2:0] imm);
        ctrl_t c = '0;
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.immsrc  = imm;
        return c;
    endfunction

    function automatic ctrl_t trap_e(input logic [1:0] f);
        ctrl_t c = '0;
        c.fault = f;
        return c;
    endfunction

    // Sets the instruction fields and checks the FETCH word with ready high.
    task automatic start(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7; mem_ready = 1'b1;
        #1;
        check(tag, obs, fetch_e(1'b1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; op = '0; func3 = '0; func7 = '0;
        zero = 1'b0; negetive = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
        #3;
        check("reset_fetch", obs, fetch_e(1'b0));
        #9;
        rst = 1'b1;

        // add x3,x1,x2
        start("add_fetch", 7'b0110011, 3'b000, 7'b0000000);
        tick(); check("add_decode", obs, decode_e(3'b000));
        tick(); e = '0; e.alusrca = 2'b10; check("add_exec", obs, e);
        tick(); e = '0; e.regwrite = 1'b1; check("add_wb", obs, e);
        tick();

        // sub
        start("sub_fetch", 7'b0110011, 3'b000, 7'b0100000);
        tick();
        tick(); e = '0; e.alusrca = 2'b10; e.aluop = 3'b001; check("sub_exec", obs, e);
        tick(); tick();

        // and (R) and xori (I)
        start("and_fetch", 7'b0110011, 3'b111, 7'b0000000);
        tick();
        tick(); e = '0; e.alusrca = 2'b10; e.aluop = 3'b010; check("and_exec", obs, e);
        tick(); tick();
        start("xori_fetch", 7'b0010011, 3'b100, 7'b0000000);
        tick(); check("xori_decode", obs, decode_e(3'b000));
        tick(); e = '0; e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 3'b110;
        check("xori_exec", obs, e);
        tick(); e = '0; e.regwrite = 1'b1; check("xori_wb", obs, e);
        tick();

        // lw with three stalled cycles
        start("lw_fetch", 7'b0000011, 3'b010, 7'b0000000);
        tick(); check("lw_decode", obs, decode_e(3'b000));
        tick(); e = '0; e.alusrca = 2'b10; e.alusrcb = 2'b01; check("lw_addr", obs, e);
        mem_ready = 1'b0;
        e = '0; e.adrsrc = 1'b1; e.memread = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check($sformatf("lw_wait%0d", i), obs, e);
        end
        tick(); mem_ready = 1'b1; #1; check("lw_ready", obs, e);
        tick(); e = '0; e.regwrite = 1'b1; e.resultsrc = 2'b01; check("lw_wb", obs, e);
        tick();

        // asynchronous reset in the middle of DECODE
        start("rstdec_fetch", 7'b0000011, 3'b010, 7'b0000000);
        tick(); check("rstdec_decode", obs, decode_e(3'b000));
        rst = 1'b0;
        #1; check("rstdec_async", obs, fetch_e(1'b1));
        rst = 1'b1;

        // sw
        start("sw_fetch", 7'b0100011, 3'b010, 7'b0000000);
        tick(); check("sw_decode", obs, decode_e(3'b001));
        tick(); e = '0; e.alusrca = 2'b10; e.alusrcb = 2'b01; e.immsrc = 3'b001;
        check("sw_addr", obs, e);
        tick(); e = '0; e.adrsrc = 1'b1; e.memwrite = 1'b1; check("sw_write", obs, e);
        tick(); check("sw_done", obs, fetch_e(1'b1));

        // beq
        start("beq_fetch", 7'b1100011, 3'b000, 7'b0000000);
        tick(); check("beq_decode", obs, decode_e(3'b010));
        tick(); zero = 1'b1; #1;
        e = '0; e.alusrca = 2'b10; e.aluop = 3'b001; e.pcsrc = 1'b1; e.immsrc = 3'b010;
        e.pcwrite = 1'b1; check("beq_taken", obs, e);
        zero = 1'b0; #1; e.pcwrite = 1'b0; check("beq_not_taken", obs, e);
        tick();

        // bltu on both instances: legal on dut, illegal on dut0
        start("bltu_fetch", 7'b1100011, 3'b110, 7'b0000000);
        tick();
        tick(); ltu = 1'b0; #1;
        e = '0; e.alusrca = 2'b10; e.aluop = 3'b001; e.pcsrc = 1'b1; e.immsrc = 3'b010;
        check("bltu_ltu0", obs, e);
        check("bltu_nobr_branch", obs0, e);
        ltu = 1'b1; #1;
        check("bltu_nobr_ltu1", obs0, e);
        e.pcwrite = 1'b1; check("bltu_ltu1", obs, e);
        tick(); ltu = 1'b0;
        check("bltu_next", obs, fetch_e(1'b1));
        check("bltu_nobr_trap", obs0, trap_e(2'b01));

        // jal
        start("jal_fetch", 7'b1101111, 3'b000, 7'b0000000);
        tick(); check("jal_decode", obs, decode_e(3'b011));
        tick(); e = '0; e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcsrc = 1'b1; e.pcwrite = 1'b1;
        e.regwrite = 1'b1; e.resultsrc = 2'b10; e.immsrc = 3'b011; check("jal_exec", obs, e);
        tick(); check("jal_done", obs, fetch_e(1'b1));

        // jalr
        start("jalr_fetch", 7'b1100111, 3'b000, 7'b0000000);
        tick(); check("jalr_decode", obs, decode_e(3'b000));
        tick(); e = '0; e.alusrca = 2'b01; e.alusrcb = 2'b10; check("jalr_1", obs, e);
        tick(); e = '0; e.alusrca = 2'b10; e.alusrcb = 2'b01; e.pcwrite = 1'b1; e.regwrite = 1'b1;
        check("jalr_2", obs, e);
        tick(); check("jalr_done", obs, fetch_e(1'b1));

        // lui, entered after a FETCH whose ready arrives in the last allowed cycle
        op = 7'b0110111; func3 = 3'b000; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; check($sformatf("late_wait%0d", i), obs, fetch_e(1'b0));
            tick();
        end
        mem_ready = 1'b1; #1; check("late_ready", obs, fetch_e(1'b1));
        tick(); check("lui_decode", obs, decode_e(3'b100));
        tick(); e = '0; e.regwrite = 1'b1; e.resultsrc = 2'b11; e.immsrc = 3'b100;
        check("lui_exec", obs, e);
        tick();

        // fetch timeout
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; check($sformatf("tmo_wait%0d", i), obs, fetch_e(1'b0));
            tick();
        end
        check("tmo_trap", obs, trap_e(2'b10));
        mem_ready = 1'b1;
        tick(); tick(); check("tmo_sticky", obs, trap_e(2'b10));

        // unsupported opcode
        do_reset();
        start("fence_fetch", 7'b0001111, 3'b000, 7'b0000000);
        tick(); check("fence_decode", obs, decode_e(3'b000));
        tick(); check("fence_trap", obs, trap_e(2'b01));
        tick(); tick(); check("fence_sticky", obs, trap_e(2'b01));

        // R-type func3 001
        do_reset();
        start("sll_fetch", 7'b0110011, 3'b001, 7'b0000000);
        tick();
        tick(); e = '0; e.alusrca = 2'b10; check("sll_exec", obs, e);
        tick(); check("sll_trap", obs, trap_e(2'b01));
        tick(); check("sll_sticky", obs, trap_e(2'b01));
        do_reset();
        #1; check("sll_reset", obs, fetch_e(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
